// File: rtl/ifu_prefetch_q.sv
// Sequential instruction prefetcher: keeps up to OUTS ITCM reads in flight and
// buffers {pc, instr} pairs in a DEPTH-entry FIFO towards the EXU.
module ifu_prefetch_q #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 4,
  parameter int OUTS    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PC_W-1:0]            pc_rtvec,
  input  logic                       pipe_flush_req,
  input  logic [PC_W-1:0]            pipe_flush_pc,
  output logic                       pipe_flush_ack,
  output logic                       itcm_cmd_valid,
  input  logic                       itcm_cmd_ready,
  output logic [ADDR_W-1:0]          itcm_cmd_addr,
  input  logic                       itcm_rsp_valid,
  output logic                       itcm_rsp_ready,
  input  logic [INSTR_W-1:0]         itcm_rsp_rdata,
  output logic                       ifu_o_valid,
  input  logic                       ifu_o_ready,
  output logic [INSTR_W-1:0]         ifu_o_ir,
  output logic [PC_W-1:0]            ifu_o_pc,
  output logic [$clog2(DEPTH+1)-1:0] ifu_o_cnt
);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OUT_W = $clog2(OUTS+1);

  logic [PC_W-1:0]    r_fetch_pc;
  logic [PC_W-1:0]    r_rsp_pc;
  logic [OUT_W-1:0]   r_outs;
  logic [OUT_W-1:0]   r_drop;
  logic [CNT_W-1:0]   r_cnt;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [INSTR_W-1:0] r_ir_mem [DEPTH];
  logic [PC_W-1:0]    r_pc_mem [DEPTH];

  logic               w_cmd_fire;
  logic               w_rsp_fire;
  logic               w_push;
  logic               w_pop;
  logic               w_credit_ok;
  logic [31:0]        w_credit;
  logic [PC_W-1:0]    w_flush_pc;
  logic [PC_W-1:0]    w_rtvec_pc;
  logic               w_unused;

  // Handshakes: a transfer happens on a cycle where valid && ready; cmd valid may
  // drop without a transfer, responses are always accepted, the EXU pops the head.
  assign w_flush_pc = {pipe_flush_pc[PC_W-1:2], 2'b00};
  assign w_rtvec_pc = {pc_rtvec[PC_W-1:2], 2'b00};
  assign w_unused   = ^{pc_rtvec[1:0], pipe_flush_pc[1:0]};

  // Reserve a FIFO slot for every read whose data will be kept.
  assign w_credit    = 32'(r_cnt) + 32'(r_outs) - 32'(r_drop);
  assign w_credit_ok = (w_credit < 32'(DEPTH)) && (32'(r_outs) < 32'(OUTS));

  assign itcm_cmd_valid = !rst && !pipe_flush_req && w_credit_ok;
  assign itcm_cmd_addr  = r_fetch_pc[ADDR_W-1:0];
  assign itcm_rsp_ready = 1'b1;
  assign pipe_flush_ack = pipe_flush_req && !rst;

  assign w_cmd_fire = itcm_cmd_valid && itcm_cmd_ready;
  assign w_rsp_fire = itcm_rsp_valid && (r_outs != '0);
  assign w_push     = w_rsp_fire && (r_drop == '0) && !pipe_flush_req;
  assign w_pop      = ifu_o_valid && ifu_o_ready && !pipe_flush_req;

  assign ifu_o_valid = !rst && (r_cnt != '0);
  assign ifu_o_cnt   = rst ? '0 : r_cnt;
  assign ifu_o_ir    = r_ir_mem[r_rd_ptr];
  assign ifu_o_pc    = r_pc_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= w_rtvec_pc;
      r_rsp_pc   <= w_rtvec_pc;
      r_outs     <= '0;
      r_drop     <= '0;
      r_cnt      <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else if (pipe_flush_req) begin
      // Everything still outstanding after this cycle belongs to the old stream.
      r_fetch_pc <= w_flush_pc;
      r_rsp_pc   <= w_flush_pc;
      r_outs     <= r_outs - OUT_W'(w_rsp_fire);
      r_drop     <= r_outs - OUT_W'(w_rsp_fire);
      r_cnt      <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      if (w_cmd_fire) begin
        r_fetch_pc <= r_fetch_pc + PC_W'(4);
      end
      r_outs <= r_outs + OUT_W'(w_cmd_fire) - OUT_W'(w_rsp_fire);
      if (w_rsp_fire && (r_drop != '0)) begin
        r_drop <= r_drop - OUT_W'(1);
      end
      if (w_push) begin
        r_rsp_pc <= r_rsp_pc + PC_W'(4);
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Payload storage carries no reset; occupancy alone qualifies it.
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_ir_mem[r_wr_ptr] <= itcm_rsp_rdata;
      r_pc_mem[r_wr_ptr] <= r_rsp_pc;
    end
  end

endmodule

// File: tb/tb_ifu_prefetch_q.sv
// Bench for ifu_prefetch_q: randomized ITCM/EXU traffic against a queue model,
// plus a second OUTS=1/DEPTH=2 instance running with a toggling cmd_ready.
`timescale 1ns/1ps
module tb_ifu_prefetch_q;
  localparam int PC_W = 32, INSTR_W = 32, ADDR_W = 16, DEPTH = 4, OUTS = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main instance signals
  logic [PC_W-1:0]    pc_rtvec;
  logic               pipe_flush_req, pipe_flush_ack;
  logic [PC_W-1:0]    pipe_flush_pc;
  logic               itcm_cmd_valid, itcm_cmd_ready;
  logic [ADDR_W-1:0]  itcm_cmd_addr;
  logic               itcm_rsp_valid, itcm_rsp_ready;
  logic [INSTR_W-1:0] itcm_rsp_rdata;
  logic               ifu_o_valid, ifu_o_ready;
  logic [INSTR_W-1:0] ifu_o_ir;
  logic [PC_W-1:0]    ifu_o_pc;
  logic [2:0]         ifu_o_cnt;

  // small instance signals
  logic               s_flush_req, s_flush_ack;
  logic [PC_W-1:0]    s_flush_pc;
  logic               s_cmd_valid, s_cmd_ready;
  logic [ADDR_W-1:0]  s_cmd_addr;
  logic               s_rsp_valid, s_rsp_ready;
  logic [INSTR_W-1:0] s_rsp_rdata;
  logic               s_o_valid, s_o_ready;
  logic [INSTR_W-1:0] s_o_ir;
  logic [PC_W-1:0]    s_o_pc;
  logic [1:0]         s_o_cnt;

  ifu_prefetch_q #(.PC_W(PC_W), .INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .OUTS(OUTS)) u_dut (
    .clk(clk), .rst(rst), .pc_rtvec(pc_rtvec),
    .pipe_flush_req(pipe_flush_req), .pipe_flush_pc(pipe_flush_pc), .pipe_flush_ack(pipe_flush_ack),
    .itcm_cmd_valid(itcm_cmd_valid), .itcm_cmd_ready(itcm_cmd_ready), .itcm_cmd_addr(itcm_cmd_addr),
    .itcm_rsp_valid(itcm_rsp_valid), .itcm_rsp_ready(itcm_rsp_ready), .itcm_rsp_rdata(itcm_rsp_rdata),
    .ifu_o_valid(ifu_o_valid), .ifu_o_ready(ifu_o_ready), .ifu_o_ir(ifu_o_ir), .ifu_o_pc(ifu_o_pc),
    .ifu_o_cnt(ifu_o_cnt)
  );

  ifu_prefetch_q #(.PC_W(PC_W), .INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .DEPTH(2), .OUTS(1)) u_small (
    .clk(clk), .rst(rst), .pc_rtvec(32'h0000_0402),
    .pipe_flush_req(s_flush_req), .pipe_flush_pc(s_flush_pc), .pipe_flush_ack(s_flush_ack),
    .itcm_cmd_valid(s_cmd_valid), .itcm_cmd_ready(s_cmd_ready), .itcm_cmd_addr(s_cmd_addr),
    .itcm_rsp_valid(s_rsp_valid), .itcm_rsp_ready(s_rsp_ready), .itcm_rsp_rdata(s_rsp_rdata),
    .ifu_o_valid(s_o_valid), .ifu_o_ready(s_o_ready), .ifu_o_ir(s_o_ir), .ifu_o_pc(s_o_pc),
    .ifu_o_cnt(s_o_cnt)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return (32'(a) * 32'h9e37_79b1) ^ 32'h1234_5678;
  endfunction

  // Reads accepted by the ITCM model, tagged with the fetch stream they belong to.
  typedef struct {
    logic [31:0] pc;
    logic [15:0] addr;
    int          epoch;
    int          due;
  } rd_t;

  rd_t         itcm_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_cmd_pc;
  int          epoch, cyc, last_due;
  int          lat_min, lat_max, cmd_rdy_pct, o_rdy_pct;

  logic        smp_ack, smp_cmd_valid, smp_o_valid, smp_fire, smp_pop;
  logic [31:0] smp_fire_addr, smp_pop_pc;
  int          smp_cnt;

  // ---------------- driver tasks ----------------
  task automatic step(input bit fl, input logic [31:0] fpc);
    int  n_cur;
    int  due;
    bit  exp_valid, rsp, pop, fire;
    rd_t e;
    pipe_flush_req = fl;
    pipe_flush_pc  = fpc;
    itcm_cmd_ready = ($urandom_range(0, 99) < cmd_rdy_pct);
    ifu_o_ready    = ($urandom_range(0, 99) < o_rdy_pct);
    rsp = (itcm_q.size() > 0) && (itcm_q[0].due <= cyc);
    itcm_rsp_valid = rsp;
    itcm_rsp_rdata = rsp ? mem_word(itcm_q[0].addr) : $urandom;
    #1;
    n_cur = 0;
    foreach (itcm_q[i]) if (itcm_q[i].epoch == epoch) n_cur++;
    exp_valid = !fl && (itcm_q.size() < OUTS) && (exp_q.size() + n_cur < DEPTH);
    check("flush_ack", pipe_flush_ack, fl);
    check("rsp_ready", itcm_rsp_ready, 1);
    check("cmd_valid", itcm_cmd_valid, exp_valid);
    if (exp_valid) check("cmd_addr", itcm_cmd_addr, exp_cmd_pc[15:0]);
    check("o_cnt", ifu_o_cnt, exp_q.size());
    check("o_valid", ifu_o_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("o_pc", ifu_o_pc, exp_q[0]);
      check("o_ir", ifu_o_ir, mem_word(exp_q[0][15:0]));
    end
    fire          = itcm_cmd_valid && itcm_cmd_ready;
    pop           = !fl && (exp_q.size() != 0) && ifu_o_ready;
    smp_ack       = pipe_flush_ack;
    smp_cmd_valid = itcm_cmd_valid;
    smp_o_valid   = ifu_o_valid;
    smp_cnt       = int'(ifu_o_cnt);
    smp_fire      = fire;
    smp_fire_addr = 32'(itcm_cmd_addr);
    smp_pop       = ifu_o_valid && ifu_o_ready;
    smp_pop_pc    = ifu_o_pc;
    @(posedge clk);
    if (rsp) begin
      e = itcm_q.pop_front();
      if (!fl && e.epoch == epoch) exp_q.push_back(e.pc);
    end
    if (fl) begin
      exp_q.delete();
      epoch++;
      exp_cmd_pc = fpc & ~32'h3;
    end else if (pop) begin
      void'(exp_q.pop_front());
    end
    if (fire) begin
      due = cyc + $urandom_range(lat_min, lat_max);
      if (due < last_due) due = last_due;
      last_due = due;
      itcm_q.push_back('{pc: exp_cmd_pc, addr: itcm_cmd_addr, epoch: epoch, due: due});
      exp_cmd_pc += 32'd4;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [31:0] vec);
    rst      = 1'b1;
    pc_rtvec = vec;
    for (int i = 0; i < 3; i++) begin
      pipe_flush_req = (i == 1);
      pipe_flush_pc  = $urandom;
      itcm_cmd_ready = 1'b1;
      ifu_o_ready    = 1'b1;
      itcm_rsp_valid = 1'b0;
      itcm_rsp_rdata = '0;
      @(posedge clk);
      #1;
      check("rst_cmd_valid", itcm_cmd_valid, 0);
      check("rst_flush_ack", pipe_flush_ack, 0);
      check("rst_o_valid", ifu_o_valid, 0);
      check("rst_o_cnt", ifu_o_cnt, 0);
      @(negedge clk);
    end
    rst = 1'b0;
    itcm_q.delete();
    exp_q.delete();
    epoch      = 0;
    cyc        = 0;
    last_due   = 0;
    exp_cmd_pc = vec & ~32'h3;
  endtask

  // Steps after a flush: the FIFO is empty at once, and the new stream starts at exp_pc.
  task automatic watch_first(input int n, input string tag, input logic [31:0] exp_pc);
    bit gf = 0, gp = 0;
    for (int i = 0; i < n && !(gf && gp); i++) begin
      step(0, 0);
      if (i == 0) begin
        check({tag, "_cnt_after"}, smp_cnt, 0);
        check({tag, "_valid_after"}, smp_o_valid, 0);
      end
      if (smp_fire && !gf) begin
        gf = 1;
        check({tag, "_first_addr"}, smp_fire_addr, exp_pc);
      end
      if (smp_pop && !gp) begin
        gp = 1;
        check({tag, "_first_pc"}, smp_pop_pc, exp_pc);
      end
    end
    check({tag, "_seen"}, {gf, gp}, 2'b11);
  endtask

  // ---------------- main stimulus ----------------
  initial begin : main_seq
    int  n;
    int  np;
    bit  found;
    bit  got_fire;
    logic [31:0] fa;
    rst = 1'b1;
    pipe_flush_req = 1'b0;
    pipe_flush_pc  = '0;
    itcm_cmd_ready = 1'b0;
    itcm_rsp_valid = 1'b0;
    itcm_rsp_rdata = '0;
    ifu_o_ready    = 1'b0;
    pc_rtvec       = '0;
    @(negedge clk);
    do_reset(32'h0000_0100);

    // Straight-line fetch with a 1-cycle ITCM.
    lat_min = 1; lat_max = 1; cmd_rdy_pct = 100; o_rdy_pct = 100;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 0);
      if (i == 0) check("s1_addr0", smp_fire_addr, 32'h100);
      if (i == 1) check("s1_valid_c1", smp_o_valid, 0);
      if (i == 2) begin
        check("s1_valid_c2", smp_o_valid, 1);
        check("s1_pc_c2", smp_pop_pc, 32'h100);
      end
      if (smp_pop) n++;
    end
    check("s1_tput", n, 18);

    // EXU stalled: the FIFO fills to DEPTH and fetch stops.
    o_rdy_pct = 0;
    step(1, 32'h100);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0);
      if (smp_fire) n++;
    end
    check("s2_fires", n, 4);
    check("s2_cnt", smp_cnt, 4);
    check("s2_cmd_hold", smp_cmd_valid, 0);
    o_rdy_pct = 100;
    np = 0; got_fire = 0; fa = '0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0);
      if (smp_fire && !got_fire) begin
        got_fire = 1;
        fa = smp_fire_addr;
      end
      if (smp_pop && np < 4) begin
        check("s2_pop_pc", smp_pop_pc, 32'h100 + 32'(4 * np));
        np++;
      end
    end
    check("s2_npops", np, 4);
    check("s2_resume", fa, 32'h110);

    // Two reads in flight on a 2-cycle ITCM, then redirect.
    lat_min = 2; lat_max = 2;
    for (int i = 0; i < 8; i++) step(0, 0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (itcm_q.size() == 2) begin
        found = 1;
        step(1, 32'h2000);
        check("s3_ack", smp_ack, 1);
      end else begin
        step(0, 0);
      end
    end
    check("s3_armed", found, 1);
    watch_first(30, "s3", 32'h2000);

    // Misaligned redirect target.
    lat_min = 1; lat_max = 2; o_rdy_pct = 70;
    for (int i = 0; i < 5; i++) step(0, 0);
    step(1, 32'h2003);
    watch_first(30, "s4", 32'h2000);

    // Flush colliding with a response and a pop while one entry is held.
    lat_min = 1; lat_max = 1; o_rdy_pct = 100; cmd_rdy_pct = 100;
    for (int i = 0; i < 6; i++) step(0, 0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (exp_q.size() == 1 && itcm_q.size() > 0 && itcm_q[0].due <= cyc) begin
        found = 1;
        step(1, 32'h3000);
        check("s5_pre_cnt", smp_cnt, 1);
      end else begin
        step(0, 0);
      end
    end
    check("s5_armed", found, 1);
    watch_first(30, "s5", 32'h3000);

    // Random soak, including a stream that wraps past the top of the PC space.
    lat_min = 1; lat_max = 3; cmd_rdy_pct = 70; o_rdy_pct = 60;
    step(1, 32'hFFFF_FFF8);
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) < 3) step(1, $urandom);
      else step(0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- small instance: OUTS=1, DEPTH=2, cmd_ready toggling ----------------
  initial begin : small_seq
    logic [31:0] s_exp_cmd;
    logic [31:0] s_exp_q[$];
    logic [31:0] s_itcm_pc[$];
    logic [15:0] s_itcm_addr[$];
    bit          tog, rsp, fire, pop, exp_valid;
    s_flush_req = 1'b0;
    s_flush_pc  = '0;
    s_cmd_ready = 1'b0;
    s_o_ready   = 1'b0;
    s_rsp_valid = 1'b0;
    s_rsp_rdata = '0;
    @(negedge clk);
    while (rst !== 1'b0) @(negedge clk);
    s_exp_cmd = 32'h400;
    tog = 1'b1;
    forever begin
      s_cmd_ready = tog;
      tog = !tog;
      s_o_ready = ($urandom_range(0, 1) == 1);
      rsp = (s_itcm_pc.size() > 0);
      s_rsp_valid = rsp;
      s_rsp_rdata = rsp ? mem_word(s_itcm_addr[0]) : $urandom;
      #1;
      exp_valid = (s_itcm_pc.size() == 0) && (s_exp_q.size() + s_itcm_pc.size() < 2);
      check("sm_cmd_valid", s_cmd_valid, exp_valid);
      if (exp_valid) check("sm_cmd_addr", s_cmd_addr, s_exp_cmd[15:0]);
      check("sm_cnt", s_o_cnt, s_exp_q.size());
      if (s_exp_q.size() != 0) begin
        check("sm_o_pc", s_o_pc, s_exp_q[0]);
        check("sm_o_ir", s_o_ir, mem_word(s_exp_q[0][15:0]));
      end
      fire = s_cmd_valid && s_cmd_ready;
      pop  = (s_exp_q.size() != 0) && s_o_ready;
      @(posedge clk);
      if (rsp) begin
        s_exp_q.push_back(s_itcm_pc.pop_front());
        void'(s_itcm_addr.pop_front());
      end
      if (pop) void'(s_exp_q.pop_front());
      if (fire) begin
        s_itcm_pc.push_back(s_exp_cmd);
        s_itcm_addr.push_back(s_cmd_addr);
        s_exp_cmd += 32'd4;
      end
      @(negedge clk);
    end
  end

endmodule

// File: doc/ifu_prefetch_q.md
Name: ifu_prefetch_q

Overview:
- Parametrised sequential prefetch engine for the IFU, next generation of the single-request ifetch-to-ITCM path.
- Keeps up to OUTS ITCM reads in flight at PC, PC+4, PC+8, and so on.
- Buffers returned instructions with their PCs in a DEPTH-entry FIFO and presents them to the EXU with a valid/ready handshake.
- A pipeline flush redirects fetch to a new PC and silently drops every response still in flight.

Parameters:
- PC_W, 32, PC and flush-target width.
- INSTR_W, 32, instruction width; equals ITCM read data width.
- ADDR_W, 16, ITCM byte-address width; ADDR_W <= PC_W.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- OUTS, 2, maximum outstanding ITCM reads; 1 <= OUTS <= DEPTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- pc_rtvec  in  PC_W  reset PC; bits [1:0] ignored.
- pipe_flush_req  in  1  redirect request.
- pipe_flush_pc  in  PC_W  redirect target; bits [1:0] forced to 0.
- pipe_flush_ack  out  1  flush accepted.
- itcm_cmd_valid  out  1  read request.
- itcm_cmd_ready  in  1  ITCM accepts request.
- itcm_cmd_addr  out  ADDR_W  byte address equal to fetch_pc[ADDR_W-1:0].
- itcm_rsp_valid  in  1  read data return, strictly in order.
- itcm_rsp_ready  out  1  tied to 1.
- itcm_rsp_rdata  in  INSTR_W  instruction.
- ifu_o_valid  out  1  FIFO head valid.
- ifu_o_ready  in  1  EXU accepts head.
- ifu_o_ir  out  INSTR_W  head instruction.
- ifu_o_pc  out  PC_W  head PC.
- ifu_o_cnt  out  clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
- State:
  - fetch_pc: next address to request.
  - rsp_pc: PC assigned to the next kept response.
  - outs: in-flight read count, 0..OUTS.
  - drop: responses still to discard, 0..OUTS.
  - fifo: rd/wr pointers plus count.
- Reset (rst=1 at an edge):
  - fetch_pc = rsp_pc = {pc_rtvec[PC_W-1:2], 2'b00}.
  - outs = drop = count = 0.
- Outputs while rst=1: itcm_cmd_valid=0, pipe_flush_ack=0, ifu_o_valid=0, ifu_o_cnt=0.
- ITCM shares rst, so no response arrives for a request issued before reset.
- Issue rule: itcm_cmd_valid = !rst & !pipe_flush_req & (outs < OUTS) & (count + outs - drop < DEPTH).
  - Valid need not hold once asserted; the ITCM samples it per cycle.
  - On cmd handshake: fetch_pc += 4, outs += 1. fetch_pc wraps modulo 2^PC_W.
- Response rule: every itcm_rsp_valid beat decrements outs.
  - If drop > 0: the data is discarded and drop -= 1.
  - Otherwise the pair {rsp_pc, rdata} is pushed and rsp_pc += 4.
  - The credit rule guarantees that a push never meets a full FIFO.
  - itcm_rsp_valid with outs == 0 is a protocol violation and is ignored.
- Output side:
  - ifu_o_valid = (count != 0); ir and pc come from the head entry.
  - Pop on ifu_o_valid & ifu_o_ready.
  - Push and pop in the same cycle leave count unchanged, including at count == DEPTH-1 and count == 1.
- Flush:
  - pipe_flush_ack = pipe_flush_req & !rst, combinational; a flush is accepted in the same cycle.
  - In the flush cycle:
    - the FIFO is cleared and any pop that cycle is void;
    - a response arriving that cycle is discarded;
    - fetch_pc = rsp_pc = target;
    - drop = outs - rsp_valid, i.e. all reads still outstanding after this cycle;
    - no request is issued.
  - Back-to-back flushes: each one recomputes drop the same way; the last target wins.
- Latency:
  - With an ITCM of cmd_ready=1 and 1-cycle response, the request issues in cycle 0 after reset release or flush.
  - Data is pushed at the edge ending cycle 1; ifu_o_valid=1 in cycle 2.
  - Sustained throughput is 1 instruction/cycle when OUTS >= 2 and DEPTH >= 3.

Test Plan:
- Reset with pc_rtvec=0x0000_0100, ITCM 1-cycle, ifu_o_ready=1 -> cmd_addr sequence 0x100, 0x104, 0x108…; ifu_o_pc 0x100 in cycle 2, then one instruction per cycle, ifu_o_ir matching memory.
- Hold ifu_o_ready=0, default parameters -> exactly 4 requests issued, ifu_o_cnt reaches 4 and holds, itcm_cmd_valid=0; release ready -> 4 pops in PC order, then fetch resumes at 0x110.
- Two reads in flight (ITCM 2-cycle latency), flush to 0x2000 -> pipe_flush_ack=1 the same cycle, FIFO empty the next cycle, both stale responses dropped, first ifu_o_pc=0x2000.
- Flush with pipe_flush_pc=0x2003 -> first ifu_o_pc=0x2000 and first cmd_addr=0x2000.
- Flush asserted in the same cycle as a response and a pop, with count=1 -> count=0, response not pushed, drop=outs-1, no spurious ifu_o_valid.
- OUTS=1, DEPTH=2, cmd_ready toggling 1/0 -> never more than 1 read in flight, PCs strictly +4, no FIFO overflow.
